// File: rtl/serial_pair_serializer_most_significant_first.sv
// Bit-serial transmitter for an (A, B) word pair with first/last framing for the serial comparator.
// Define SERIAL_SERIALIZER_LSB_FIRST_EN to emit least-significant bit first instead of MSB first.
module serial_pair_serializer_most_significant_first #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_a,
  output logic             out_b,
  output logic             out_first,
  output logic             out_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] shift_a, shift_b, shift_a_nxt, shift_b_nxt;
  logic [WIDTH-1:0] shifted_a, shifted_b;
  logic             busy, last, take, beat, head_a, head_b;

`ifdef SERIAL_SERIALIZER_LSB_FIRST_EN
  assign head_a    = shift_a[0];
  assign head_b    = shift_b[0];
  assign shifted_a = shift_a >> 1;
  assign shifted_b = shift_b >> 1;
`else
  assign head_a    = shift_a[WIDTH-1];
  assign head_b    = shift_b[WIDTH-1];
  assign shifted_a = shift_a << 1;
  assign shifted_b = shift_b << 1;
`endif

  // Every serial output is masked while rst is asserted so nothing leaks during reset.
  assign busy      = (state == SHIFT) && !rst;
  assign last      = busy && (cnt == LAST_BEAT);
  assign in_ready  = !rst && ((state == IDLE) || (last && out_ready));
  assign take      = in_valid && in_ready;
  assign beat      = busy && out_ready;

  assign out_valid = busy;
  assign out_a     = busy && head_a;
  assign out_b     = busy && head_b;
  assign out_first = busy && (cnt == '0);
  assign out_last  = last;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    shift_a_nxt = shift_a;
    shift_b_nxt = shift_b;
    // A reload on the last beat keeps the line busy with no bubble.
    if (take) begin
      state_nxt   = SHIFT;
      cnt_nxt     = '0;
      shift_a_nxt = in_a;
      shift_b_nxt = in_b;
    end else if (beat) begin
      if (last) begin
        state_nxt = IDLE;
      end else begin
        cnt_nxt     = cnt + CW'(1);
        shift_a_nxt = shifted_a;
        shift_b_nxt = shifted_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift_a <= '0;
      shift_b <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      shift_a <= shift_a_nxt;
      shift_b <= shift_b_nxt;
    end
  end

endmodule

// File: doc/serial_pair_serializer_most_significant_first.md
Name: serial_pair_serializer_most_significant_first

Overview:
- Transmit side of the serial comparator interface.
- Accepts a pair of parallel words (A, B) through a valid/ready handshake.
- Shifts both words out bit-serially, one bit per beat, most significant bit first, on two lockstep lines.
- Framing outputs (first/last) let the downstream serial comparator restart and sample its result at each word boundary.

Parameters:
- WIDTH, 8, word width in bits; legal range 2 to 64.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  parallel word pair offered
- in_ready  output  1  block can accept a word pair this cycle
- in_a  input  WIDTH  word A
- in_b  input  WIDTH  word B
- out_valid  output  1  serial beat present
- out_ready  input  1  downstream accepts the beat this cycle
- out_a  output  1  current bit of A
- out_b  output  1  current bit of B
- out_first  output  1  beat carries bit WIDTH-1 (first beat of a word)
- out_last  output  1  beat carries bit 0 (last beat of a word)

Behaviour:
- Reset:
  - rst is synchronous, active-high; clock is clk.
  - On rst, the state machine goes to IDLE, the beat counter clears to 0 and both shift registers clear to 0.
  - While rst is high and in the cycle after: out_valid=0, out_a=0, out_b=0, out_first=0, out_last=0.
  - in_ready is forced 0 while rst is high.
- Registers:
  - shift_a and shift_b, each WIDTH bits.
  - Beat counter, $clog2(WIDTH) bits.
  - 1-bit state: IDLE or SHIFT.
- Transfers:
  - Input transfer occurs when in_valid & in_ready. Output beat transfer occurs when out_valid & out_ready.
  - in_ready = ~rst & (IDLE | (SHIFT & out_last & out_ready)).
  - in_ready never depends on in_valid (no combinational loop).
- IDLE state:
  - On an input transfer: load the shift registers from in_a/in_b, counter=0, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT state:
  - out_valid=1, out_a=shift_a[WIDTH-1], out_b=shift_b[WIDTH-1].
  - out_first=(counter==0), out_last=(counter==WIDTH-1).
  - On a beat transfer that is not the last beat: shift both registers left by 1 (zero fill) and increment the counter.
  - On the last-beat transfer with a simultaneous input transfer: reload the shift registers, counter=0, stay in SHIFT. This is back-to-back operation with no bubble.
  - On the last-beat transfer with no input transfer: go to IDLE.
  - out_ready=0: all state and outputs hold (stall of any length, any beat).
- Outputs come straight from registers. out_first, out_last, out_a and out_b are 0 whenever out_valid=0.
- Latency and throughput:
  - Word accepted at clock edge k: its MSB beat is valid in the cycle after edge k.
  - With out_ready held at 1, the word takes exactly WIDTH cycles.
  - Sustained throughput is one word per WIDTH cycles.
- Counter wrap: the counter never exceeds WIDTH-1. It resets to 0 only on a reload or on rst.
- Reset mid-word: remaining beats are discarded and no partial word is resumed. After reset the next accepted word starts with out_first.
- in_a/in_b are sampled only at the input transfer. Later changes have no effect on the word in flight.

Optional Feature:
- Macro: SERIAL_SERIALIZER_LSB_FIRST_EN.
- Defined:
  - Bits are emitted least significant first: out_a=shift_a[0], out_b=shift_b[0], shift right with zero fill.
  - out_first marks the bit-0 beat and out_last marks the bit-WIDTH-1 beat.
  - This output feeds the least-significant-first comparator.
- Not defined: MSB-first behaviour exactly as specified above.
- The handshake, timing and counter are identical in both builds.

Test Plan:
- Single word, WIDTH=8, in_a=8'hA5, in_b=8'hA3, out_ready=1:
  - out_a sequence is 1,0,1,0,0,1,0,1; out_b sequence is 1,0,1,0,0,0,1,1.
  - out_first=1 on beat 0 only; out_last=1 on beat 7 only.
  - in_ready=0 on beats 0-6 and 1 on beat 7; out_valid=0 on the cycle after beat 7.
- Back-to-back: in_valid held 1 with 8'hFF/8'h00 then 8'h0F/8'hF0:
  - 16 consecutive valid beats with no gap.
  - out_first asserts on beats 0 and 8.
  - Second word's out_a sequence is 0,0,0,0,1,1,1,1.
- Backpressure: out_ready=0 for 3 cycles while beat 3 of 8'hA5 is presented:
  - out_a=0 and counter=3 held for all 3 cycles.
  - Serial sequence resumes unchanged; in_ready stays 0 throughout.
- Stall on the last beat: out_ready=0 during beat 7 with in_valid=1:
  - in_ready=0 and the new word is not accepted.
  - When out_ready returns to 1, the new word is accepted in that same cycle and its MSB follows next cycle.
- Reset mid-word: rst at beat 4:
  - Next cycle: out_valid=0, all outputs 0.
  - The next word (8'h81/8'h7E) starts with out_first=1, out_a=1, out_b=0.
- Build with SERIAL_SERIALIZER_LSB_FIRST_EN, in_a=8'hA5:
  - out_a sequence is 1,0,1,0,0,1,0,1 reversed, i.e. 1,0,1,0,0,1,0,1 read from bit 0.
  - With in_a=8'h01: out_a=1 on the out_first beat, 0 on all other beats.
